alu_muldiv_unit: RTL
====================

Name: alu_muldiv_unit

Overview:
- Parametrised execute-stage ALU for the MIPS pipeline.
- Combinational datapath: the existing 3-bit ALUControl op set, widened to WIDTH and completed with NOR, XOR, SLTU and signed SLT.
- Sequential path: an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake, used by the hazard unit to stall MFHI/MFLO.

Parameters:
- WIDTH, 32, datapath width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B
- ALUControl  input  3  combinational op select
- ALU_Result  output  WIDTH  combinational result
- Zero  output  1  ALU_Result == 0
- md_start  input  1  launch mul/div/move op (one-cycle request)
- md_op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- md_busy  output  1  iteration in progress
- md_done  output  1  one-cycle pulse: HI/LO updated
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clocking: single clock domain; reset sampled only on the rising clk edge.
- Combinational ALU, zero latency:
  - 000 AND; 001 OR; 010 ADD; 110 SUB.
  - 111 signed SLT: result {WIDTH-1 zeros, A<B signed}.
  - 011 SLTU: same format, unsigned compare.
  - 100 NOR; 101 XOR.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - No default case; all 8 codes are defined.
- Reset: hi=0, lo=0, md_busy=0, md_done=0, counter=0, FSM=IDLE. Reset mid-iteration aborts, leaves no partial result in HI/LO, and produces no md_done.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - md_start=1 with op 10/11: write SrcA to hi/lo at that edge; go to DONE. md_busy never rises.
  - md_start=1 with op 00/01: latch SrcA and SrcB; counter=WIDTH; go to MUL or DIV.
- MUL (shift-add, one bit per cycle):
  - Accumulator is 2·WIDTH bits; multiplier LSB selects add of the multiplicand into the upper half, then shift right 1.
  - Counter decrements each cycle; at counter==1 the next edge writes {hi,lo} = product and goes to DONE.
- DIV (restoring, one quotient bit per cycle):
  - Shift remainder/quotient left; trial-subtract divisor; keep if non-negative and set quotient bit.
  - Final edge writes lo=quotient, hi=remainder.
  - Divide by zero: no iteration; DIV takes 1 cycle, then lo={WIDTH{1}}, hi=SrcA, done as normal.
- DONE: md_done=1 for exactly one cycle; return to IDLE. md_start in DONE is accepted as in IDLE (back-to-back ops).
- Latency: with start sampled at edge N, md_busy=1 during cycles N+1..N+WIDTH and md_done=1 in cycle N+WIDTH+1. HI/LO are valid from the start of that cycle. MTHI/MTLO: md_done in cycle N+1.
- md_start while md_busy=1 is ignored; no queueing, no error.
- Operand registers are captured at start; SrcA/SrcB may change freely during iteration.
- hi/lo hold their value when not written. The combinational ALU is fully usable while md_busy=1.

Optional Feature:
- Macro: ALU_MULDIV_SIGNED_EN.
- Defined: md_start carries a 3-bit-equivalent extension via an extra input md_signed (1 bit).
  - md_signed=1 with op 00/01: operands are converted to magnitudes at start and the result sign is fixed in the final cycle (+1 cycle latency).
  - Signed divide: remainder takes the sign of the dividend, quotient truncates toward zero.
  - Divide by zero is handled as above.
  - Most-negative/−1 gives lo=most-negative, hi=0.
- Undefined: md_signed is absent and all mul/div is unsigned.

Test Plan:
- Reset then ALU sweep, WIDTH=32: A=0xFFFFFFFE, B=0x00000001.
  - SLT=1, SLTU=0, SUB=0xFFFFFFFD, NOR=0x00000000, ADD=0xFFFFFFFF, Zero=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF: md_busy high exactly 32 cycles; md_done in cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100÷7: lo=14, hi=2.
  - Then DIVU 5÷0: lo=0xFFFFFFFF, hi=5, md_done 2 cycles after start.
- Start MULTU 3×4, pulse md_start DIVU at cycle 10, then assert reset at cycle 20.
  - Second start ignored; after reset hi=lo=0, md_busy=0, no md_done.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles: each gives md_done next cycle, md_busy stays 0; final hi=0xDEADBEEF, lo=0x12345678.
- ALU_MULDIV_SIGNED_EN defined, signed DIV −7÷2: lo=0xFFFFFFFD, hi=0xFFFFFFFF; md_done in cycle 34.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: MIPS execute-stage ALU plus iterative multiply/divide unit with HI/LO registers.
//   Optional feature macro: ALU_MULDIV_SIGNED_EN adds the md_signed input (signed MULT/DIV).
//   Ports: clk, reset          - clock, synchronous active-high reset
//          SrcA, SrcB          - operands (ALU and mul/div/move)
//          ALUControl          - combinational op select -> ALU_Result, Zero
//          md_start, md_op     - launch MULTU/DIVU/MTHI/MTLO
//          md_busy, md_done    - iteration in progress / one-cycle HI/LO update pulse
//          hi, lo              - HI/LO registers
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero,
  input  logic             md_start,
  input  logic [1:0]       md_op,
`ifdef ALU_MULDIV_SIGNED_EN
  input  logic             md_signed,
`endif
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
`ifdef ALU_MULDIV_SIGNED_EN
    FIX,
`endif
    DONE
  } state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   a_mag, b_mag, a_orig;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] mul_nx, div_nx, it_nx;
`ifdef ALU_MULDIV_SIGNED_EN
  logic               sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d, is_div_q, is_div_d;
  logic               neg_a, neg_b;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
`endif
  always_comb begin
    ALU_Result = '0;
    case (ALUControl)
      3'b000: ALU_Result = SrcA & SrcB;
      3'b001: ALU_Result = SrcA | SrcB;
      3'b010: ALU_Result = SrcA + SrcB;
      3'b011: ALU_Result = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      3'b100: ALU_Result = ~(SrcA | SrcB);
      3'b101: ALU_Result = SrcA ^ SrcB;
      3'b110: ALU_Result = SrcA - SrcB;
      3'b111: ALU_Result = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
    endcase
  end
  assign Zero = ALU_Result == '0;
  // One iteration step for both engines; acc_q holds {upper, lower} halves.
  // MUL: lower = remaining multiplier bits, upper = partial product.
  // DIV: upper = partial remainder, lower = dividend bits shifting into quotient.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
    mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge  = rem_sh >= {1'b0, opb_q};
    // When the trial subtract succeeds the true difference is below the divisor, so WIDTH bits suffice.
    rem_sub = rem_sh[WIDTH-1:0] - opb_q;
    div_nx  = {rem_ge ? rem_sub : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], rem_ge};
    it_nx   = state_q == DIV ? div_nx : mul_nx;
  end
`ifdef ALU_MULDIV_SIGNED_EN
  // Signed ops run on magnitudes; the sign is restored in the FIX cycle.
  always_comb begin
    neg_a  = md_signed & SrcA[WIDTH-1];
    neg_b  = md_signed & SrcB[WIDTH-1];
    a_mag  = neg_a ? -SrcA : SrcA;
    b_mag  = neg_b ? -SrcB : SrcB;
    a_orig = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    prod_s = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_s  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end
`else
  assign a_mag  = SrcA;
  assign b_mag  = SrcB;
  assign a_orig = acc_q[WIDTH-1:0];
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef ALU_MULDIV_SIGNED_EN
    sgn_d    = sgn_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    is_div_d = is_div_q;
`endif
    if (state_q == IDLE || state_q == DONE) begin
      state_d = IDLE;
      if (md_start && md_op[1]) begin
        hi_d    = md_op[0] ? hi_q : SrcA;
        lo_d    = md_op[0] ? SrcA : lo_q;
        state_d = DONE;
      end else if (md_start) begin
        acc_d   = {{WIDTH{1'b0}}, a_mag};
        opb_d   = b_mag;
        cnt_d   = CNT_W'(WIDTH);
        state_d = md_op[0] ? DIV : MUL;
`ifdef ALU_MULDIV_SIGNED_EN
        sgn_d    = md_signed;
        neg_a_d  = neg_a;
        neg_b_d  = neg_b;
        is_div_d = md_op[0];
`endif
      end
    end else if (state_q == MUL || state_q == DIV) begin
      acc_d = it_nx;
      cnt_d = cnt_q - CNT_W'(1);
      if (state_q == DIV && opb_q == '0) begin
        // Divide by zero skips iteration: all-ones quotient, dividend as remainder.
        hi_d    = a_orig;
        lo_d    = '1;
        cnt_d   = '0;
        state_d = DONE;
      end else if (cnt_q == CNT_W'(1)) begin
        hi_d    = it_nx[2*WIDTH-1:WIDTH];
        lo_d    = it_nx[WIDTH-1:0];
        state_d = DONE;
`ifdef ALU_MULDIV_SIGNED_EN
        if (sgn_q) begin
          hi_d    = hi_q;
          lo_d    = lo_q;
          state_d = FIX;
        end
`endif
      end
    end
`ifdef ALU_MULDIV_SIGNED_EN
    else begin
      hi_d    = is_div_q ? rem_s : prod_s[2*WIDTH-1:WIDTH];
      lo_d    = is_div_q ? quo_s : prod_s[WIDTH-1:0];
      state_d = DONE;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
      sgn_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef ALU_MULDIV_SIGNED_EN
      sgn_q    <= sgn_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      is_div_q <= is_div_d;
`endif
    end
  end
`ifdef ALU_MULDIV_SIGNED_EN
  assign md_busy = state_q == MUL || state_q == DIV || state_q == FIX;
`else
  assign md_busy = state_q == MUL || state_q == DIV;
`endif
  assign md_done = state_q == DONE;
  assign hi      = hi_q;
  assign lo      = lo_q;
endmodule
